// File: rtl/johnson_count_param.sv
// Parametrised Johnson counter with enable, up/down direction and parallel load.
// Decodes the state into a binary phase index with a wrap pulse and self-corrects illegal states.
module johnson_count_param #(
   parameter int WIDTH = 8,
   parameter int PW    = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             r,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             err
);

   logic [WIDTH-1:0] out_reg, out_next;
   logic [PW-1:0]    phase_reg, phase_next;
   logic             wrap_reg, wrap_next;
   logic             err_reg, err_next;
   logic [WIDTH-2:0] out_diff, ld_diff;
   logic             out_legal, ld_legal;

   // A legal Johnson state has at most one boundary between adjacent bits.
   for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_diff
      assign out_diff[gi] = out_reg[gi] ^ out_reg[gi+1];
      assign ld_diff[gi]  = load_val[gi] ^ load_val[gi+1];
   end

   assign out_legal = ($countones(out_diff) <= 1);
   assign ld_legal  = ($countones(ld_diff) <= 1);

   // Low-ones states sit in the first half of the sequence, high-ones states in the second.
   function automatic logic [PW-1:0] johnson_index(input logic [WIDTH-1:0] v);
      int ones;
      ones = $countones(v);
      if (ones == 0)
         return '0;
      else if (v[0])
         return PW'(ones);
      else
         return PW'(2 * WIDTH - ones);
   endfunction

   always_comb begin
      out_next  = out_reg;
      wrap_next = 1'b0;
      err_next  = 1'b0;
      if (!out_legal) begin
         out_next = '0;
         err_next = 1'b1;
      end else if (load) begin
         if (ld_legal)
            out_next = load_val;
         else
            err_next = 1'b1;
      end else if (en) begin
         if (up) begin
            out_next  = {out_reg[WIDTH-2:0], ~out_reg[WIDTH-1]};
            wrap_next = (phase_reg == PW'(2 * WIDTH - 1));
         end else begin
            out_next  = {~out_reg[0], out_reg[WIDTH-1:1]};
            wrap_next = (phase_reg == '0);
         end
      end
      phase_next = johnson_index(out_next);
   end

   always_ff @(posedge clk) begin
      if (r) begin
         out_reg   <= '0;
         phase_reg <= '0;
         wrap_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         out_reg   <= out_next;
         phase_reg <= phase_next;
         wrap_reg  <= wrap_next;
         err_reg   <= err_next;
      end
   end

   assign out   = out_reg;
   assign phase = phase_reg;
   assign wrap  = wrap_reg;
   assign err   = err_reg;

endmodule

// File: tb/tb_johnson_count_param.sv
// Directed bench for johnson_count_param: an 8-bit instance and a 2-bit instance
// driven side by side, with hand-computed expected values.
module tb_johnson_count_param;

   logic       clk = 1'b0;
   logic       r = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [7:0] out;
   logic [3:0] phase;
   logic       wrap, err;

   logic       r2 = 1'b0, en2 = 1'b0;
   logic [1:0] out2;
   logic [1:0] phase2;
   logic       wrap2, err2;

   int errors = 0;
   int checks = 0;

   logic [7:0] fwd_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
   logic [1:0] w2_tab [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

   johnson_count_param #(.WIDTH(8)) dut (
      .clk(clk), .r(r), .en(en), .up(up), .load(load), .load_val(load_val),
      .out(out), .phase(phase), .wrap(wrap), .err(err)
   );

   johnson_count_param #(.WIDTH(2)) dut2 (
      .clk(clk), .r(r2), .en(en2), .up(1'b1), .load(1'b0), .load_val(2'b00),
      .out(out2), .phase(phase2), .wrap(wrap2), .err(err2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] e_out, input logic [3:0] e_ph,
                       input logic e_wrap, input logic e_err);
      $display("%s: out=%02h phase=%0d wrap=%0b err=%0b", tag, out, phase, wrap, err);
      chk({tag, ".out"},   32'(out),   32'(e_out));
      chk({tag, ".phase"}, 32'(phase), 32'(e_ph));
      chk({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
      chk({tag, ".err"},   32'(err),   32'(e_err));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset both instances
      r = 1'b1; r2 = 1'b1;
      tick();
      r = 1'b0; r2 = 1'b0;
      chk8("reset", 8'h00, 4'd0, 1'b0, 1'b0);

      // full forward cycle, wrap only on return to zero
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk8($sformatf("fwd%0d", i), fwd_tab[i], 4'((i + 1) % 16), (i == 15), 1'b0);
      end

      // reverse from zero wraps to phase 15
      r = 1'b1;
      tick();
      r = 1'b0; up = 1'b0;
      tick();
      chk8("rev0", 8'h80, 4'd15, 1'b1, 1'b0);
      tick();
      chk8("rev1", 8'hC0, 4'd14, 1'b0, 1'b0);

      // immediate direction reversal, then forward wrap 15 -> 0
      up = 1'b1;
      tick();
      chk8("turn", 8'h80, 4'd15, 1'b0, 1'b0);
      tick();
      chk8("fwdwrap", 8'h00, 4'd0, 1'b1, 1'b0);

      // legal load overrides enable and clears wrap
      load = 1'b1; load_val = 8'h0F;
      tick();
      chk8("load_ok", 8'h0F, 4'd4, 1'b0, 1'b0);
      load_val = 8'h05;
      tick();
      chk8("load_bad", 8'h0F, 4'd4, 1'b0, 1'b1);
      load = 1'b0; en = 1'b0;
      tick();
      chk8("hold", 8'h0F, 4'd4, 1'b0, 1'b0);

      // plant an illegal state, then let it self-correct
      force dut.out_reg = 8'h5A;
      #1;
      release dut.out_reg;
      chk("forced", 32'(out), 32'h5A);
      en = 1'b1; up = 1'b1;
      tick();
      chk8("correct", 8'h00, 4'd0, 1'b0, 1'b1);
      tick();
      chk8("after", 8'h01, 4'd1, 1'b0, 1'b0);

      // count on to phase 9, then reset wins over load and enable
      for (int i = 1; i < 9; i++) tick();
      chk8("ph9", 8'hFE, 4'd9, 1'b0, 1'b0);
      r = 1'b1; load = 1'b1; load_val = 8'h3F;
      tick();
      chk8("midreset", 8'h00, 4'd0, 1'b0, 1'b0);
      r = 1'b0; load = 1'b0; en = 1'b0;

      // WIDTH=2 instance forward cycle
      $display("w2 reset: out=%02b phase=%0d", out2, phase2);
      chk("w2.reset.out", 32'(out2), 32'h0);
      en2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         $display("w2 step%0d: out=%02b phase=%0d wrap=%0b err=%0b", i, out2, phase2, wrap2, err2);
         chk($sformatf("w2.out%0d", i),   32'(out2),   32'(w2_tab[i]));
         chk($sformatf("w2.phase%0d", i), 32'(phase2), 32'((i + 1) % 4));
         chk($sformatf("w2.wrap%0d", i),  32'(wrap2),  32'(i == 3));
         chk($sformatf("w2.err%0d", i),   32'(err2),   32'h0);
      end
      en2 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
